// File: rtl/conv_pkg.sv
// Shared widths and state encoding for the convolution operand feeder.
package conv_pkg;

    localparam int DATA_W   = 8;
    localparam int OUT_W    = 16;
    localparam int STRIDE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        STREAM = 2'd2,
        WAIT   = 2'd3
    } state_t;

endpackage

// File: rtl/conv_operand_ram.sv
// Image and kernel register stores with one write port and a shared read index.
module conv_operand_ram
    import conv_pkg::*;
#(
    parameter int M  = 3,
    parameter int F  = 2,
    parameter int AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [DATA_W-1:0] img_rd,
    output logic [DATA_W-1:0] ker_rd
);

    localparam int NI = M * M;
    localparam int NK = F * F;

    logic [DATA_W-1:0] img [NI];
    logic [DATA_W-1:0] ker [NK];

    // Address decode by match, so out-of-range addresses hit no entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NI; i++) img[i] <= '0;
            for (int i = 0; i < NK; i++) ker[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NI; i++)
                if (!wr_sel && wr_addr == AW'(i)) img[i] <= wr_data;
            for (int i = 0; i < NK; i++)
                if (wr_sel && wr_addr == AW'(i)) ker[i] <= wr_data;
        end
    end

    // Kernel reads past F*F fall through to zero padding.
    always_comb begin
        img_rd = '0;
        ker_rd = '0;
        for (int i = 0; i < NI; i++)
            if (rd_idx == AW'(i)) img_rd = img[i];
        for (int i = 0; i < NK; i++)
            if (rd_idx == AW'(i)) ker_rd = ker[i];
    end

endmodule

// File: rtl/conv_operand_feeder.sv
// Loads image/kernel, streams them serially to the engine and captures its result.
module conv_operand_feeder
    import conv_pkg::*;
#(
    parameter  int M       = 3,
    parameter  int F       = 2,
    parameter  int TIMEOUT = 256,
    localparam int AW      = (M * M > 1) ? $clog2(M * M) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_sel,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                start,
    input  logic [STRIDE_W-1:0] stride_in,
    output logic                eng_rst,
    output logic [DATA_W-1:0]   a,
    output logic [DATA_W-1:0]   b,
    output logic [STRIDE_W-1:0] stride,
    input  logic [OUT_W-1:0]    eng_out,
    input  logic                eng_done,
    output logic                busy,
    output logic [OUT_W-1:0]    res,
    output logic                res_valid,
    output logic                err
);

    localparam int NI = M * M;
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t            state, state_d;
    logic [AW-1:0]     k;
    logic [WW-1:0]     wcnt;
    logic [DATA_W-1:0] img_rd, ker_rd;
    logic              go, last_k, tmo;

    assign go     = start && (stride_in != '0);
    assign last_k = (k == AW'(NI - 1));
    assign tmo    = (wcnt == WW'(TIMEOUT - 1));

    conv_operand_ram #(.M(M), .F(F), .AW(AW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en && state == IDLE),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (k),
        .img_rd  (img_rd),
        .ker_rd  (ker_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (go) state_d = ARM;
            ARM:     state_d = STREAM;
            STREAM:  if (last_k) state_d = WAIT;
            WAIT:    if (eng_done || tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_rst   <= 1'b1;
            a         <= '0;
            b         <= '0;
            stride    <= '0;
            busy      <= 1'b0;
            res       <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            k         <= '0;
            wcnt      <= '0;
        end else begin
            res_valid <= 1'b0;
            a         <= '0;
            b         <= '0;
            unique case (state)
                IDLE: begin
                    k <= '0;
                    if (go) begin
                        stride  <= stride_in;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                        eng_rst <= 1'b0;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                ARM: begin
                    k <= '0;
                end
                STREAM: begin
                    a    <= img_rd;
                    b    <= ker_rd;
                    k    <= last_k ? '0 : k + AW'(1);
                    wcnt <= '0;
                end
                WAIT: begin
                    if (eng_done) begin
                        res       <= eng_out;
                        res_valid <= 1'b1;
                        busy      <= 1'b0;
                        eng_rst   <= 1'b1;
                    end else if (tmo) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        eng_rst <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
